// File: rtl/wf_slot_tracker_pkg.sv
// Shared definitions for the wavefront-slot tracker and its consumers
// (dispatcher, scoreboard): default geometry, slot-id type, error codes.
// No logic; types and constants only.
package wf_slot_tracker_pkg;

    localparam int WF_NUM_SLOTS = 40;
    localparam int WF_ID_W      = 6;
    localparam int WF_NUM_REL   = 2;

    typedef logic [WF_ID_W-1:0] slot_id_t;

    // Error classes reported by the tracker; the scoreboard logs these codes.
    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ALLOC = 2'd1,
        ERR_REL   = 2'd2
    } err_code_t;

endpackage

// File: rtl/wf_prio_enc.sv
// Lowest-set-bit priority encoder over a slot bitmap.
// Latency: combinational. Backpressure: none.
// Ports: vec (bitmap in), id (index of lowest set bit, 0 if none), any (vec != 0).
module wf_prio_enc
    import wf_slot_tracker_pkg::*;
#(
    parameter int NUM_SLOTS = WF_NUM_SLOTS,
    parameter int ID_W      = WF_ID_W
) (
    input  logic [NUM_SLOTS-1:0] vec,
    output logic [ID_W-1:0]      id,
    output logic                 any
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        id = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = ID_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/wf_slot_tracker.sv
// Registered wavefront-slot vacancy tracker: allocations, multi-port releases, flush.
// Latency: 1 cycle from sampled request to every output; one allocation per cycle sustained.
// Backpressure: none; illegal requests are dropped and flagged with one-cycle error pulses.
// Ports: clk, rst (async active-low), flush, alloc_vld/alloc_id, rel_vld/rel_id (packed per port);
//        vacant bitmap, free_vld/free_id (lowest free), occ_cnt, full, empty, err_alloc, err_rel.
module wf_slot_tracker
    import wf_slot_tracker_pkg::*;
#(
    parameter int   NUM_SLOTS = WF_NUM_SLOTS,
    parameter int   ID_W      = WF_ID_W,
    parameter int   NUM_REL   = WF_NUM_REL,
    localparam int  CNT_W     = $clog2(NUM_SLOTS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    alloc_vld,
    input  logic [ID_W-1:0]         alloc_id,
    input  logic [NUM_REL-1:0]      rel_vld,
    input  logic [NUM_REL*ID_W-1:0] rel_id,
    output logic [NUM_SLOTS-1:0]    vacant,
    output logic                    free_vld,
    output logic [ID_W-1:0]         free_id,
    output logic [CNT_W-1:0]        occ_cnt,
    output logic                    full,
    output logic                    empty,
    output logic                    err_alloc,
    output logic                    err_rel
);

    logic [NUM_SLOTS-1:0]              r_vacant;
    logic                              r_free_vld;
    logic [ID_W-1:0]                   r_free_id;
    logic [CNT_W-1:0]                  r_occ_cnt;
    logic                              r_full;
    logic                              r_empty;
    logic                              r_err_alloc;
    logic                              r_err_rel;

    logic [NUM_SLOTS-1:0]              w_alloc_dec;
    logic [NUM_REL-1:0][NUM_SLOTS-1:0] w_rel_dec;
    logic [NUM_SLOTS-1:0]              w_rel_mask;
    logic [NUM_REL-1:0]                w_rel_bad;
    logic [NUM_SLOTS-1:0]              w_alloc_mask;
    logic [NUM_SLOTS-1:0]              w_next_vacant;
    logic [CNT_W-1:0]                  w_next_cnt;
    logic [ID_W-1:0]                   w_free_id;
    logic                              w_free_any;

    // One-hot decodes gated by their strobes. An id >= NUM_SLOTS matches no
    // slot, so an all-zero decode on a valid strobe means "out of range".
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_dec
        assign w_alloc_dec[s] = alloc_vld && (alloc_id == ID_W'(s));
        for (genvar k = 0; k < NUM_REL; k++) begin : g_rel
            assign w_rel_dec[k][s] = rel_vld[k] && (rel_id[k*ID_W +: ID_W] == ID_W'(s));
        end
    end

    // A release only counts against an occupied slot in the registered state;
    // two ports naming the same slot simply OR into the mask.
    always_comb begin
        logic [NUM_SLOTS-1:0] w_hit;
        w_rel_mask = '0;
        w_rel_bad  = '0;
        for (int k = 0; k < NUM_REL; k++) begin
            w_hit        = w_rel_dec[k] & ~r_vacant;
            w_rel_mask   = w_rel_mask | w_hit;
            w_rel_bad[k] = rel_vld[k] && !(|w_hit);
        end
    end

    // Same-cycle release makes the slot claimable again (back-to-back reuse).
    assign w_alloc_mask  = w_alloc_dec & (r_vacant | w_rel_mask);
    assign w_next_vacant = flush ? '1 : ((r_vacant | w_rel_mask) & ~w_alloc_mask);

    always_comb begin
        w_next_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!w_next_vacant[i]) begin
                w_next_cnt = w_next_cnt + CNT_W'(1);
            end
        end
    end

    // Encoding the next state keeps free_id aligned with vacant after the edge.
    wf_prio_enc #(
        .NUM_SLOTS (NUM_SLOTS),
        .ID_W      (ID_W)
    ) u_prio_enc (
        .vec (w_next_vacant),
        .id  (w_free_id),
        .any (w_free_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vacant    <= '1;
            r_free_vld  <= 1'b1;
            r_free_id   <= '0;
            r_occ_cnt   <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_err_alloc <= 1'b0;
            r_err_rel   <= 1'b0;
        end else begin
            r_vacant    <= w_next_vacant;
            r_free_vld  <= w_free_any;
            r_free_id   <= w_free_id;
            r_occ_cnt   <= w_next_cnt;
            r_full      <= (w_next_cnt == CNT_W'(NUM_SLOTS));
            r_empty     <= (w_next_cnt == '0);
            r_err_alloc <= !flush && alloc_vld && !(|w_alloc_mask);
            r_err_rel   <= !flush && (|w_rel_bad);
        end
    end

    assign vacant    = r_vacant;
    assign free_vld  = r_free_vld;
    assign free_id   = r_free_id;
    assign occ_cnt   = r_occ_cnt;
    assign full      = r_full;
    assign empty     = r_empty;
    assign err_alloc = r_err_alloc;
    assign err_rel   = r_err_rel;

endmodule

// File: tb/tb_wf_slot_tracker.sv
// Self-checking bench for wf_slot_tracker: a reference model predicts every
// cycle's outputs into a scoreboard queue, popped and compared after the edge.
// Directed scenarios followed by a randomized stretch and a mid-cycle reset.
module tb_wf_slot_tracker;
    import wf_slot_tracker_pkg::*;

    localparam int NS = 40;
    localparam int IW = 6;
    localparam int NR = 2;
    localparam int CW = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             alloc_vld = 1'b0;
    logic [IW-1:0]    alloc_id = '0;
    logic [NR-1:0]    rel_vld = '0;
    logic [NR*IW-1:0] rel_id = '0;
    logic [NS-1:0]    vacant;
    logic             free_vld;
    logic [IW-1:0]    free_id;
    logic [CW-1:0]    occ_cnt;
    logic             full;
    logic             empty;
    logic             err_alloc;
    logic             err_rel;

    wf_slot_tracker #(
        .NUM_SLOTS (NS),
        .ID_W      (IW),
        .NUM_REL   (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .alloc_vld (alloc_vld),
        .alloc_id  (alloc_id),
        .rel_vld   (rel_vld),
        .rel_id    (rel_id),
        .vacant    (vacant),
        .free_vld  (free_vld),
        .free_id   (free_id),
        .occ_cnt   (occ_cnt),
        .full      (full),
        .empty     (empty),
        .err_alloc (err_alloc),
        .err_rel   (err_rel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] vac;
        logic          fv;
        logic [IW-1:0] fid;
        logic [CW-1:0] cnt;
        logic          full;
        logic          empty;
        logic          ea;
        logic          er;
    } exp_t;

    exp_t          sb_q[$];
    logic [NS-1:0] m_vac;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model_out(input logic [NS-1:0] v, input logic ea, input logic er);
        exp_t e;
        int   c;
        e.vac = v;
        e.fv  = |v;
        e.fid = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (v[i]) e.fid = IW'(i);
        end
        c       = NS - $countones(v);
        e.cnt   = CW'(c);
        e.full  = (c == NS);
        e.empty = (c == 0);
        e.ea    = ea;
        e.er    = er;
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: got no expectation, required one queued");
        end else begin
            e = sb_q.pop_front();
            check("vacant",    64'(vacant),    64'(e.vac));
            check("free_vld",  64'(free_vld),  64'(e.fv));
            check("free_id",   64'(free_id),   64'(e.fid));
            check("occ_cnt",   64'(occ_cnt),   64'(e.cnt));
            check("full",      64'(full),      64'(e.full));
            check("empty",     64'(empty),     64'(e.empty));
            check("err_alloc", 64'(err_alloc), 64'(e.ea));
            check("err_rel",   64'(err_rel),   64'(e.er));
        end
    endtask

    // Drive one cycle of stimulus, predict its effect, then check after the edge.
    task automatic cycle(input logic f, input logic av, input int aid,
                         input logic [NR-1:0] rv, input int r0, input int r1);
        int            rid[NR];
        logic [NS-1:0] rm;
        logic [NS-1:0] nv;
        logic          ea;
        logic          er;
        logic          aok;
        flush     = f;
        alloc_vld = av;
        alloc_id  = IW'(aid);
        rel_vld   = rv;
        rel_id    = {IW'(r1), IW'(r0)};
        rid[0] = r0;
        rid[1] = r1;
        rm = '0;
        er = 1'b0;
        for (int k = 0; k < NR; k++) begin
            if (rv[k]) begin
                if (rid[k] < NS && !m_vac[rid[k]]) rm[rid[k]] = 1'b1;
                else                               er = 1'b1;
            end
        end
        aok = av && (aid < NS) && (m_vac[aid] || rm[aid]);
        ea  = av && !aok;
        if (f) begin
            nv = '1;
            ea = 1'b0;
            er = 1'b0;
        end else begin
            nv = m_vac | rm;
            if (aok) nv[aid] = 1'b0;
        end
        m_vac = nv;
        sb_q.push_back(model_out(nv, ea, er));
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 2'b00, 0, 0);
    endtask

    initial begin
        // Power-on reset, asserted away from any clock edge.
        #1 rst = 1'b0;
        #1;
        m_vac = '1;
        sb_q.push_back(model_out('1, 1'b0, 1'b0));
        check_out();
        @(negedge clk);
        rst = 1'b1;

        // Fill all slots by taking free_id every cycle.
        for (int i = 0; i < NS; i++) begin
            check("alloc_seq_id", 64'(free_id), 64'(i));
            cycle(1'b0, 1'b1, int'(free_id), 2'b00, 0, 0);
        end
        check("full_after_fill", 64'(full), 64'd1);
        check("occ_after_fill",  64'(occ_cnt), 64'd40);

        // Release slots 20..39, two ports per cycle.
        for (int j = 0; j < 10; j++) begin
            cycle(1'b0, 1'b0, 0, 2'b11, 20 + 2*j, 21 + 2*j);
        end

        // Dual release of 17 and 3 in one cycle.
        cycle(1'b0, 1'b0, 0, 2'b11, 17, 3);
        check("dual_rel_free_id", 64'(free_id), 64'd3);
        check("dual_rel_occ",     64'(occ_cnt), 64'd18);
        cycle(1'b0, 1'b1, 3, 2'b00, 0, 0);
        cycle(1'b0, 1'b1, 17, 2'b00, 0, 0);

        // Release and re-allocate slot 5 in the same cycle.
        cycle(1'b0, 1'b1, 5, 2'b01, 5, 0);
        check("reuse_slot5", 64'(vacant[5]), 64'd0);
        check("reuse_occ",   64'(occ_cnt),   64'd20);

        // Illegal requests: occupied alloc, out-of-range alloc, vacant release.
        cycle(1'b0, 1'b1, 9, 2'b00, 0, 0);
        cycle(1'b0, 1'b1, 45, 2'b00, 0, 0);
        cycle(1'b0, 1'b0, 0, 2'b01, 12, 0);
        cycle(1'b0, 1'b0, 0, 2'b01, 12, 0);
        cycle(1'b0, 1'b1, 12, 2'b00, 0, 0);
        // Both ports on the same occupied slot, then reclaim it.
        cycle(1'b0, 1'b0, 0, 2'b11, 12, 12);
        cycle(1'b0, 1'b1, 12, 2'b00, 0, 0);
        // One good and one out-of-range release together.
        cycle(1'b0, 1'b0, 0, 2'b11, 0, 50);
        cycle(1'b0, 1'b1, 0, 2'b00, 0, 0);
        idle();

        // Flush with concurrent alloc and releases (including a bad one).
        cycle(1'b1, 1'b1, 25, 2'b11, 4, 50);
        check("flush_empty", 64'(empty), 64'd1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic f;
            logic av;
            int   aid;
            f   = ($urandom_range(0, 40) == 0);
            av  = $urandom_range(0, 3) != 0;
            aid = ($urandom_range(0, 1) == 1) ? int'(free_id) : int'($urandom_range(0, 47));
            cycle(f, av, aid, NR'($urandom_range(0, 3)),
                  int'($urandom_range(0, 47)), int'($urandom_range(0, 47)));
        end

        // Reset asserted mid-cycle with an allocation in flight.
        cycle(1'b0, 1'b1, 0, 2'b00, 0, 0);
        cycle(1'b0, 1'b1, 1, 2'b00, 0, 0);
        flush     = 1'b0;
        rel_vld   = '0;
        alloc_vld = 1'b1;
        alloc_id  = IW'(7);
        #3 rst = 1'b0;
        #1;
        m_vac = '1;
        sb_q.push_back(model_out('1, 1'b0, 1'b0));
        check_out();
        #1 rst = 1'b1;
        cycle(1'b0, 1'b1, 0, 2'b00, 0, 0);
        check("post_rst_alloc0", 64'(vacant[0]), 64'd0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
